xge_rx_pkt_reader: RTL and testbench

XGE_RX_PKT_READER -- requirements
Module: xge_rx_pkt_reader

---
 rtl/xge_rx_pkt_reader.sv | 141 ++++++++++++++
 tb/tb_xge_rx_pkt_reader.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xge_rx_pkt_reader.sv
// XGE MAC rx reader: pulls frames from the MAC into a small output FIFO.
// Optional frame/error counters are enabled by XGE_RX_READER_STATS_EN.
module xge_rx_pkt_reader #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk_156m25,
    input  logic        reset_156m25_n,
    input  logic        pkt_rx_avail,
    output logic        pkt_rx_ren,
    input  logic        pkt_rx_val,
    input  logic [63:0] pkt_rx_data,
    input  logic        pkt_rx_sop,
    input  logic        pkt_rx_eop,
    input  logic        pkt_rx_err,
    input  logic [2:0]  pkt_rx_mod,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic [2:0]  out_mod,
    output logic        out_sop,
    output logic        out_eop,
    output logic        out_err,
    output logic        ovf_sticky,
    output logic [31:0] frame_cnt,
    output logic [31:0] err_frame_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = 70;
    localparam logic [AW:0] DEPTH_C  = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] FREE_MAX = DEPTH_C - (AW+1)'(2);

    typedef enum logic {
        IDLE,
        READ
    } state_t;

    state_t        state;
    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          in_frame;

    logic          free_ge2;
    logic          full;
    logic          rd_en;
    logic          keep;
    logic          wr_en;
    logic          eop_seen;
    logic [EW-1:0] wr_word;
    logic [EW-1:0] head;

    assign free_ge2 = (count <= FREE_MAX);
    assign full     = (count == DEPTH_C);
    assign out_valid = (count != '0);
    assign rd_en    = out_valid && out_ready;
    assign eop_seen = pkt_rx_val && pkt_rx_eop;

    // Words outside a frame are only accepted if they open one.
    assign keep  = pkt_rx_val && (pkt_rx_sop || in_frame);
    assign wr_en = keep && (!full || rd_en);

    // A sop inside an open frame marks the truncated frame's restart as errored.
    assign wr_word = {pkt_rx_data, pkt_rx_mod, pkt_rx_sop, pkt_rx_eop,
                      pkt_rx_err | (pkt_rx_sop & in_frame)};

    assign pkt_rx_ren = (state == READ) && free_ge2 && !eop_seen;

    always_ff @(posedge clk_156m25) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_word;
        end
    end

    assign head = mem[rd_ptr];
    assign {out_data, out_mod, out_sop, out_eop, out_err} =
        out_valid ? head : '0;

    always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
        if (!reset_156m25_n) begin
            state <= IDLE;
        end else begin
            unique case (state)
                IDLE: if (pkt_rx_avail && free_ge2) state <= READ;
                READ: if (eop_seen) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
        if (!reset_156m25_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            in_frame   <= 1'b0;
            ovf_sticky <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr   <= wr_ptr + 1'b1;
                in_frame <= !pkt_rx_eop;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_en && !rd_en) begin
                count <= count + 1'b1;
            end else if (rd_en && !wr_en) begin
                count <= count - 1'b1;
            end
            if (keep && full && !rd_en) begin
                ovf_sticky <= 1'b1;
            end
        end
    end

`ifdef XGE_RX_READER_STATS_EN
    logic [31:0] frame_q;
    logic [31:0] err_q;

    always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
        if (!reset_156m25_n) begin
            frame_q <= '0;
            err_q   <= '0;
        end else if (rd_en && out_eop) begin
            frame_q <= frame_q + 32'd1;
            if (out_err) begin
                err_q <= err_q + 32'd1;
            end
        end
    end

    assign frame_cnt     = frame_q;
    assign err_frame_cnt = err_q;
`else
    assign frame_cnt     = '0;
    assign err_frame_cnt = '0;
`endif

endmodule

// File: tb/tb_xge_rx_pkt_reader.sv
// Bench for xge_rx_pkt_reader: MAC model, queue-based reference model,
// per-cycle compare plus directed scenarios with literal expectations.
module tb_xge_rx_pkt_reader;

    localparam int DEPTH = 4;
    typedef logic [69:0] word_t;

`ifdef XGE_RX_READER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pkt_rx_avail = 1'b0;
    logic        pkt_rx_ren;
    logic        pkt_rx_val = 1'b0;
    logic [63:0] pkt_rx_data = '0;
    logic        pkt_rx_sop = 1'b0;
    logic        pkt_rx_eop = 1'b0;
    logic        pkt_rx_err = 1'b0;
    logic [2:0]  pkt_rx_mod = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_data;
    logic [2:0]  out_mod;
    logic        out_sop;
    logic        out_eop;
    logic        out_err;
    logic        ovf_sticky;
    logic [31:0] frame_cnt;
    logic [31:0] err_frame_cnt;

    xge_rx_pkt_reader #(.FIFO_DEPTH(DEPTH)) dut (
        .clk_156m25     (clk),
        .reset_156m25_n (rst_n),
        .pkt_rx_avail   (pkt_rx_avail),
        .pkt_rx_ren     (pkt_rx_ren),
        .pkt_rx_val     (pkt_rx_val),
        .pkt_rx_data    (pkt_rx_data),
        .pkt_rx_sop     (pkt_rx_sop),
        .pkt_rx_eop     (pkt_rx_eop),
        .pkt_rx_err     (pkt_rx_err),
        .pkt_rx_mod     (pkt_rx_mod),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_mod        (out_mod),
        .out_sop        (out_sop),
        .out_eop        (out_eop),
        .out_err        (out_err),
        .ovf_sticky     (ovf_sticky),
        .frame_cnt      (frame_cnt),
        .err_frame_cnt  (err_frame_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input word_t act, input word_t exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // MAC model: answers a read enable seen at an edge one cycle later.
    word_t mac_q[$];
    word_t inj_q[$];
    logic  ren_s = 1'b0;

    always @(negedge clk) ren_s = pkt_rx_ren;

    always @(posedge clk) begin
        word_t w;
        logic  v;
        #1;
        w = '0;
        v = 1'b0;
        if (inj_q.size() != 0) begin
            w = inj_q.pop_front();
            v = 1'b1;
        end else if (ren_s && mac_q.size() != 0) begin
            w = mac_q.pop_front();
            v = 1'b1;
        end
        pkt_rx_val = v;
        {pkt_rx_data, pkt_rx_mod, pkt_rx_sop, pkt_rx_eop, pkt_rx_err} = w;
        pkt_rx_avail = (mac_q.size() != 0);
    end

    // Reference model: buffer contents as a queue of entries.
    word_t       mq[$];
    word_t       log_q[$];
    bit          m_in_frame = 1'b0;
    bit          m_reading = 1'b0;
    bit          m_ovf = 1'b0;
    int unsigned m_fcnt = 0;
    int unsigned m_ecnt = 0;

    always @(negedge clk) begin
        word_t dut_w;
        word_t exp_w;
        int    sz;
        bit    rd;
        bit    eopv;
        if (!rst_n) begin
            mq.delete();
            m_in_frame = 1'b0;
            m_reading  = 1'b0;
            m_ovf      = 1'b0;
            m_fcnt     = 0;
            m_ecnt     = 0;
        end
        dut_w = {out_data, out_mod, out_sop, out_eop, out_err};
        sz    = mq.size();
        eopv  = pkt_rx_val && pkt_rx_eop;
        exp_w = (sz != 0) ? mq[0] : '0;
        chk("out_valid", out_valid, sz != 0);
        chk("out_word", dut_w, exp_w);
        chk("pkt_rx_ren", pkt_rx_ren,
            m_reading && (DEPTH - sz >= 2) && !eopv);
        chk("ovf_sticky", ovf_sticky, m_ovf);
        chk("frame_cnt", frame_cnt, STATS ? 32'(m_fcnt) : 32'd0);
        chk("err_frame_cnt", err_frame_cnt, STATS ? 32'(m_ecnt) : 32'd0);
        if (rst_n) begin
            rd = (sz != 0) && out_ready;
            if (rd) begin
                log_q.push_back(dut_w);
                if (mq[0][1]) begin
                    m_fcnt++;
                    if (mq[0][0]) m_ecnt++;
                end
                void'(mq.pop_front());
            end
            if (pkt_rx_val && (pkt_rx_sop || m_in_frame)) begin
                if (sz == DEPTH && !rd) begin
                    m_ovf = 1'b1;
                end else begin
                    mq.push_back({pkt_rx_data, pkt_rx_mod, pkt_rx_sop,
                                  pkt_rx_eop,
                                  pkt_rx_err | (pkt_rx_sop & m_in_frame)});
                    m_in_frame = !pkt_rx_eop;
                end
            end
            if (m_reading) begin
                if (eopv) m_reading = 1'b0;
            end else if (pkt_rx_avail && (DEPTH - sz >= 2)) begin
                m_reading = 1'b1;
            end
        end
    end

    task automatic push_frame(input int n, input logic [63:0] base,
                              input logic [2:0] mod, input logic err_last);
        for (int i = 0; i < n; i++) begin
            mac_q.push_back({base + 64'(i), (i == n-1) ? mod : 3'd0,
                             i == 0, i == n-1, (i == n-1) & err_last});
        end
    endtask

    task automatic wait_log(input int n, input string name);
        int t;
        t = 0;
        while (log_q.size() < n && t < 300) begin
            @(posedge clk);
            t++;
        end
        #2;
        chk({name, "_delivered"}, log_q.size() >= n, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t;
        idle(2);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_ren", pkt_rx_ren, 1'b0);
        chk("rst_out_data", out_data, 64'd0);
        rst_n = 1'b1;
        idle(2);

        // single 3-word frame, mod 5 on eop
        out_ready = 1'b1;
        push_frame(3, 64'h1000, 3'd5, 1'b0);
        wait_log(3, "f1");
        idle(2);
        chk("f1_w0", log_q[0], {64'h1000, 3'd0, 1'b1, 1'b0, 1'b0});
        chk("f1_w1", log_q[1], {64'h1001, 3'd0, 1'b0, 1'b0, 1'b0});
        chk("f1_w2", log_q[2], {64'h1002, 3'd5, 1'b0, 1'b1, 1'b0});
        chk("f1_frame_cnt", frame_cnt, STATS ? 32'd1 : 32'd0);
        chk("f1_idle_ren", pkt_rx_ren, 1'b0);

        // 10-word frame against a stalled sink
        out_ready = 1'b0;
        push_frame(10, 64'h2000, 3'd0, 1'b0);
        idle(20);
        chk("f2_mac_left", mac_q.size(), 6);
        chk("f2_stall_ren", pkt_rx_ren, 1'b0);
        chk("f2_ovf", ovf_sticky, 1'b0);
        out_ready = 1'b1;
        wait_log(13, "f2");
        chk("f2_first", log_q[3], {64'h2000, 3'd0, 1'b1, 1'b0, 1'b0});
        chk("f2_last", log_q[12], {64'h2009, 3'd0, 1'b0, 1'b1, 1'b0});

        // error on the eop word
        push_frame(2, 64'h3000, 3'd3, 1'b1);
        wait_log(15, "f3");
        idle(2);
        chk("f3_eop", log_q[14], {64'h3001, 3'd3, 1'b0, 1'b1, 1'b1});
        chk("f3_frame_cnt", frame_cnt, STATS ? 32'd3 : 32'd0);
        chk("f3_err_cnt", err_frame_cnt, STATS ? 32'd1 : 32'd0);

        // stray word outside a frame, then a sop inside an open frame
        inj_q.push_back({64'h4000, 3'd0, 1'b0, 1'b0, 1'b0});
        idle(5);
        chk("stray_dropped", log_q.size(), 15);
        inj_q.push_back({64'h4100, 3'd0, 1'b1, 1'b0, 1'b0});
        inj_q.push_back({64'h4101, 3'd0, 1'b1, 1'b0, 1'b0});
        inj_q.push_back({64'h4102, 3'd2, 1'b0, 1'b1, 1'b0});
        wait_log(18, "f4");
        idle(2);
        chk("f4_w0", log_q[15], {64'h4100, 3'd0, 1'b1, 1'b0, 1'b0});
        chk("f4_resop", log_q[16], {64'h4101, 3'd0, 1'b1, 1'b0, 1'b1});
        chk("f4_w2", log_q[17], {64'h4102, 3'd2, 1'b0, 1'b1, 1'b0});
        chk("f4_err_cnt", err_frame_cnt, STATS ? 32'd1 : 32'd0);

        // overflow: fifth word into a full buffer
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            inj_q.push_back({64'h5000 + 64'(i), 3'd0, i == 0, 1'b0, 1'b0});
        end
        idle(8);
        chk("ovf_set", ovf_sticky, 1'b1);
        out_ready = 1'b1;
        wait_log(22, "f5");
        inj_q.push_back({64'h5005, 3'd1, 1'b0, 1'b1, 1'b0});
        wait_log(23, "f5e");
        idle(2);
        chk("f5_last_kept", log_q[21], {64'h5003, 3'd0, 1'b0, 1'b0, 1'b0});
        chk("f5_eop", log_q[22], {64'h5005, 3'd1, 1'b0, 1'b1, 1'b0});
        chk("ovf_held", ovf_sticky, 1'b1);
        chk("f5_frame_cnt", frame_cnt, STATS ? 32'd5 : 32'd0);

        // reset in the middle of a 6-word frame
        out_ready = 1'b0;
        push_frame(6, 64'h6000, 3'd0, 1'b0);
        t = 0;
        while (mac_q.size() > 3 && t < 100) begin
            @(posedge clk);
            #2;
            t++;
        end
        chk("f6_reached_word2", mac_q.size() <= 3, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("f6_rst_out_valid", out_valid, 1'b0);
        chk("f6_rst_ovf", ovf_sticky, 1'b0);
        chk("f6_rst_out_data", out_data, 64'd0);
        idle(2);
        rst_n = 1'b1;
        out_ready = 1'b1;
        idle(15);
        chk("f6_tail_dropped", log_q.size(), 23);
        chk("f6_mac_drained", mac_q.size(), 0);
        push_frame(3, 64'h7000, 3'd6, 1'b0);
        wait_log(26, "f7");
        idle(2);
        chk("f7_w0", log_q[23], {64'h7000, 3'd0, 1'b1, 1'b0, 1'b0});
        chk("f7_w2", log_q[25], {64'h7002, 3'd6, 1'b0, 1'b1, 1'b0});
        chk("f7_frame_cnt", frame_cnt, STATS ? 32'd1 : 32'd0);

        idle(3);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
